// File: rtl/pnode.sv
// Perceptron node: decodes address/command frames from a shared byte stream, holds weight/input files,
// runs a sequential signed MAC with ReLU-clip activation. Define PNODE_SAT_EN for a saturating accumulator.
module pnode #(
  parameter int          N_IN  = 4,
  parameter int          ACC_W = 20,
  parameter logic [7:0]  BCAST = 8'hFF
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] address,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW = $clog2(N_IN + 1);
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
  localparam logic signed [ACC_W-1:0] ACT_MAX  = ACC_W'(127);

  typedef enum logic [2:0] {S_ADDR, S_CMD, S_DATA, S_RUN, S_OUT} state_t;

  state_t                   state_reg;
  logic                     in_ready_reg, out_valid_reg, busy_reg, match_reg;
  logic [7:0]               out_data_reg, result_reg;
  logic [2:0]               op_reg;
  logic [4:0]               idx_reg;
  logic [CW-1:0]            cnt_reg;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic signed [7:0]        weight_w [N_IN];
  logic signed [7:0]        x_w [N_IN];

  logic        xfer, clr_fire, wr_w, wr_x;
  logic [2:0]  cmd_op;
  logic [IW-1:0] mac_idx;
  logic signed [15:0] w_ext, x_ext, prod;
  logic [7:0]  act;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign busy      = busy_reg;

  assign xfer     = in_valid & in_ready_reg;
  assign cmd_op   = in_data[7:5];
  assign clr_fire = xfer && (state_reg == S_CMD) && match_reg && (cmd_op == 3'd5);
  assign wr_w     = xfer && (state_reg == S_DATA) && match_reg && (op_reg == 3'd1);
  assign wr_x     = xfer && (state_reg == S_DATA) && match_reg && (op_reg == 3'd2);

  // Register files live in flops: CLR must wipe every entry in a single cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_regs
      logic signed [7:0] w_q, x_q;
      always_ff @(posedge clk) begin
        if (nRst || clr_fire) begin
          w_q <= '0;
          x_q <= '0;
        end else begin
          if (wr_w && idx_reg == 5'(gi)) w_q <= in_data;
          if (wr_x && idx_reg == 5'(gi)) x_q <= in_data;
        end
      end
      assign weight_w[gi] = w_q;
      assign x_w[gi]      = x_q;
    end
  endgenerate

  assign mac_idx = cnt_reg[IW-1:0];
  assign w_ext   = 16'(weight_w[mac_idx]);
  assign x_ext   = 16'(x_w[mac_idx]);
  assign prod    = w_ext * x_ext;

`ifdef PNODE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] sum_ext;
  assign sum_ext = $signed({acc_reg[ACC_W-1], acc_reg}) + $signed((ACC_W+1)'(prod));
  // One guard bit exposes overflow; clamp toward the side the sum escaped.
  always_comb begin
    acc_next = sum_ext[ACC_W-1:0];
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1])
      acc_next = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
  end
`else
  assign acc_next = acc_reg + ACC_W'(prod);
`endif

  always_comb begin
    act = acc_reg[7:0];
    if (acc_reg <= ACC_ZERO)   act = 8'd0;
    else if (acc_reg > ACT_MAX) act = 8'd127;
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state_reg     <= S_ADDR;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      busy_reg      <= 1'b0;
      match_reg     <= 1'b0;
      op_reg        <= '0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
    end else begin
      case (state_reg)
        S_ADDR: begin
          in_ready_reg <= 1'b1;
          if (xfer) begin
            match_reg <= (in_data == address) || (in_data == BCAST);
            state_reg <= S_CMD;
          end
        end
        S_CMD: begin
          if (xfer) begin
            op_reg  <= cmd_op;
            idx_reg <= in_data[4:0];
            if (cmd_op == 3'd1 || cmd_op == 3'd2) begin
              state_reg <= S_DATA;
            end else if (match_reg && cmd_op == 3'd3) begin
              state_reg    <= S_RUN;
              in_ready_reg <= 1'b0;
              acc_reg      <= '0;
              cnt_reg      <= '0;
            end else if (match_reg && cmd_op == 3'd4) begin
              state_reg     <= S_OUT;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              out_data_reg  <= result_reg;
            end else begin
              state_reg <= S_ADDR;
            end
          end
        end
        S_DATA: begin
          if (xfer) state_reg <= S_ADDR;
        end
        S_RUN: begin
          // One MAC per cycle; the extra cycle after the last MAC latches the activation.
          if (cnt_reg == CW'(N_IN)) begin
            result_reg   <= act;
            busy_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
            state_reg    <= S_ADDR;
          end else begin
            acc_reg  <= acc_next;
            cnt_reg  <= cnt_reg + CW'(1);
            busy_reg <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= S_ADDR;
          end
        end
        default: state_reg <= S_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_pnode.sv
// Randomised frame-level bench for pnode: two nodes (ACC_W 20 and 16) share one command stream
// and are checked every cycle against an arithmetic model of weights, inputs and results.
module tb_pnode;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       nRst = 1'b1;
  logic [7:0] address = 8'h05;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b;
  logic [7:0] out_data_a, out_data_b;

  always #5 clk = ~clk;

  pnode #(.N_IN(N), .ACC_W(20), .BCAST(8'hFF)) u_a (
    .clk(clk), .nRst(nRst), .address(address), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .busy(busy_a));

  pnode #(.N_IN(N), .ACC_W(16), .BCAST(8'hFF)) u_b (
    .clk(clk), .nRst(nRst), .address(address), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .busy(busy_b));

  int checks = 0;
  int errors = 0;
  int mw[N];
  int mx[N];
  int mres_a = 0;
  int mres_b = 0;
  bit rd_window = 1'b0;
  int oxfer_a = 0;
  int oxfer_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  // Dot product with either wrap or clamp applied after every add, then the ReLU-clip.
  function automatic int run_model(input int accw);
    longint acc, hi, m;
    acc = 0;
    m   = longint'(1) << accw;
    hi  = (longint'(1) << (accw - 1)) - 1;
    for (int i = 0; i < N; i++) begin
      acc = acc + longint'(mw[i] * mx[i]);
`ifdef PNODE_SAT_EN
      if (acc > hi) acc = hi;
      if (acc < -hi - 1) acc = -hi - 1;
`else
      acc = ((acc % m) + m) % m;
      if (acc > hi) acc = acc - m;
`endif
    end
    if (acc <= 0) return 0;
    if (acc > 127) return 127;
    return int'(acc);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mw[i] = 0;
      mx[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (out_valid_a && out_ready) oxfer_a <= oxfer_a + 1;
    if (out_valid_b && out_ready) oxfer_b <= oxfer_b + 1;
  end

  // Per-cycle compare, sampled 2 time units after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (busy_a || out_valid_a) chk("in_ready_blocked_a", in_ready_a, 0);
      if (busy_b || out_valid_b) chk("in_ready_blocked_b", in_ready_b, 0);
      if (out_valid_a) begin
        chk("out_only_on_rd_a", rd_window, 1);
        chk("out_data_a", out_data_a, mres_a);
      end
      if (out_valid_b) begin
        chk("out_only_on_rd_b", rd_window, 1);
        chk("out_data_b", out_data_b, mres_b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready_a) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_run(input logic [7:0] a);
    int cnt, n;
    cnt = 0;
    n   = 0;
    send_byte(a);
    send_byte(8'h60 | 8'($urandom_range(0, 31)));
    while (!in_ready_a && n < 100) begin
      if (busy_a) cnt++;
      chk("busy_b_follows", busy_b, busy_a);
      @(negedge clk);
      n++;
    end
    chk("busy_cycles", cnt, N);
    mres_a = run_model(20);
    mres_b = run_model(16);
    $display("RUN  addr=%02h model_a=%0d model_b=%0d busy=%0d", a, mres_a, mres_b, cnt);
  endtask

  task automatic do_rd(input logic [7:0] a, input int hold, input int lit_a, input int lit_b);
    int xa, xb;
    rd_window = 1'b1;
    send_byte(a);
    send_byte(8'h80 | 8'($urandom_range(0, 31)));
    chk("rd_valid_a", out_valid_a, 1);
    chk("rd_valid_b", out_valid_b, 1);
    chk("rd_blocks_input", in_ready_a, 0);
    if (lit_a >= 0) chk("rd_literal_a", out_data_a, lit_a);
    if (lit_b >= 0) chk("rd_literal_b", out_data_b, lit_b);
    repeat (hold) @(negedge clk);
    chk("rd_held_a", out_valid_a, 1);
    xa = oxfer_a;
    xb = oxfer_b;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rd_drop_a", out_valid_a, 0);
    chk("rd_ready_back", in_ready_a, 1);
    chk("rd_single_xfer_a", oxfer_a - xa, 1);
    chk("rd_single_xfer_b", oxfer_b - xb, 1);
    rd_window = 1'b0;
    $display("RD   addr=%02h out_a=%02h out_b=%02h hold=%0d", a, out_data_a, out_data_b, hold);
  endtask

  task automatic do_frame(input logic [7:0] a, input int op, input int idx, input logic [7:0] p);
    bit m;
    m = (a == 8'h05) || (a == 8'hFF);
    if (m && op == 3) begin
      do_run(a);
    end else if (m && op == 4) begin
      do_rd(a, $urandom_range(0, 3), -1, -1);
    end else begin
      send_byte(a);
      send_byte({3'(op), 5'(idx)});
      if (op == 1 || op == 2) send_byte(p);
      if (m && op == 1 && idx < N) mw[idx] = int'($signed(p));
      if (m && op == 2 && idx < N) mx[idx] = int'($signed(p));
      if (m && op == 5) model_clear();
      $display("FRM  addr=%02h op=%0d idx=%0d data=%02h match=%0d", a, op, idx, p, m);
    end
  endtask

  initial begin
    logic [7:0] ra;
    int wv[N];
    int xv[N];
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_out_data", out_data_a, 0);
    nRst = 1'b0;

    wv = '{3, -1, 4, 0};
    xv = '{2, 5, 4, 9};
    for (int i = 0; i < N; i++) do_frame(8'h05, 1, i, 8'(wv[i]));
    for (int i = 0; i < N; i++) do_frame(8'h05, 2, i, 8'(xv[i]));
    do_run(8'h05);
    do_rd(8'h05, 0, 8'h11, 8'h11);

    // Foreign frame whose payload looks like our address, then an out-of-range index.
    do_frame(8'h06, 1, 0, 8'h55);
    do_frame(8'h06, 1, 0, 8'h05);
    do_rd(8'h05, 1, 8'h11, 8'h11);
    do_frame(8'h05, 1, 7, 8'h7F);
    do_run(8'h05);
    do_rd(8'h05, 0, 8'h11, 8'h11);

    do_frame(8'h05, 5, 3, 8'h00);
    do_frame(8'h05, 1, 0, 8'hFE);
    for (int i = 0; i < N; i++) do_frame(8'h05, 2, i, 8'd10);
    do_run(8'h05);
    do_rd(8'h05, 2, 8'h00, 8'h00);

    for (int i = 0; i < N; i++) do_frame(8'hFF, 1, i, 8'd127);
    for (int i = 0; i < N; i++) do_frame(8'hFF, 2, i, 8'd127);
    do_run(8'hFF);
`ifdef PNODE_SAT_EN
    do_rd(8'hFF, 5, 8'h7F, 8'h7F);
`else
    do_rd(8'hFF, 5, 8'h7F, 8'h00);
`endif

    // Reset two cycles into a RUN.
    send_byte(8'h05);
    send_byte(8'h60);
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("midrun_busy", busy_a, 0);
    chk("midrun_out_valid", out_valid_a, 0);
    chk("midrun_in_ready", in_ready_a, 0);
    nRst = 1'b0;
    model_clear();
    mres_a = 0;
    mres_b = 0;
    do_rd(8'h05, 0, 8'h00, 8'h00);
    for (int i = 0; i < N; i++) do_frame(8'h05, 2, i, 8'd127);
    do_run(8'h05);
    do_rd(8'h05, 0, 8'h00, 8'h00);

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 3))
        0: ra = 8'h05;
        1: ra = 8'h06;
        2: ra = 8'hFF;
        default: ra = 8'($urandom_range(0, 255));
      endcase
      do_frame(ra, $urandom_range(0, 7), $urandom_range(0, 7), 8'($urandom_range(0, 255)));
    end
    do_run(8'h05);
    do_rd(8'h05, 1, -1, -1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pnode.md
Name: pnode

Overview:
- Parametrised perceptron node with N_IN signed 8-bit inputs and weights, replacing the single-opcode control/datapath pair.
- Receives an already-deframed byte stream (valid/ready) shared by all nodes on a bus. Decodes address/command frames, holds weight and input register files, and runs a sequential multiply-accumulate with ReLU-clip activation.
- Returns the result byte on a valid/ready output stream for the serialiser.

Parameters:
N_IN, 4, number of inputs/weights (1..32)
ACC_W, 20, signed accumulator width (16..32)
BCAST, 8'hFF, broadcast address matched by every node

Ports:
clk  in  1  clock
nRst  in  1  reset; synchronous, active-high (1 = reset), sampled on rising clk
address  in  8  this node's bus address (static)
in_data  in  8  command stream byte
in_valid  in  1  in_data valid
in_ready  out  1  node accepts in_data this cycle
out_data  out  8  result byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
busy  out  1  MAC sequence in progress

Behaviour:
- Byte transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Frame format: ADDR byte, CMD byte {op[7:5], idx[4:0]}, then 1 payload byte for op 1/2 only.
- Match = (ADDR == address) | (ADDR == BCAST).
- Opcodes:
  - 0 NOP.
  - 1 WR_W: weight[idx] <= payload.
  - 2 WR_X: x[idx] <= payload.
  - 3 RUN.
  - 4 RD.
  - 5 CLR: all weights and inputs set to 0, takes effect on the CMD transfer.
  - 6/7 ignored, no payload.
- idx >= N_IN: write discarded, frame still consumed. idx is ignored for ops 0, 3, 4, 5.
- Non-matching frames are fully parsed (payload skipped) so byte alignment is kept. No side effects.
- FSM states S_ADDR, S_CMD, S_DATA, S_RUN, S_OUT:
  - S_ADDR -> S_CMD on transfer.
  - S_CMD -> S_DATA for op 1/2. S_CMD -> S_RUN for a matched RUN. S_CMD -> S_OUT for a matched RD. S_CMD -> S_ADDR otherwise.
  - S_DATA -> S_ADDR on transfer.
  - S_RUN -> S_ADDR after the last MAC.
  - S_OUT -> S_ADDR on output transfer.
- in_ready = 1 in S_ADDR/S_CMD/S_DATA, 0 in S_RUN/S_OUT.
- RUN timing: CMD transfer at edge t clears acc. MAC i (i = 0..N_IN-1) completes at edge t+1+i.
  - acc <= acc + sext(weight[i] * x[i]); the product is 16-bit signed, sign-extended to ACC_W.
  - busy = 1 from t+1 until the result register updates at edge t+N_IN+1, then busy = 0 and the state returns to S_ADDR.
- Activation: result = 0 if acc <= 0; 127 if acc > 127; else acc[7:0].
- Without saturation, acc wraps modulo 2^ACC_W.
- RD: out_valid rises the cycle after the CMD transfer with out_data = result. It holds stable until out_ready.
- Matched RUN/RD on the broadcast address behaves the same as a direct match. Each node drives its own output; bus arbitration is external.
- Reset values: weights, x, acc, result = 0; state S_ADDR; in_ready = 0 during reset, 1 after; out_valid = 0; out_data = 0; busy = 0.
- Reset mid-RUN or mid-frame aborts immediately. Partial frames are discarded.
- in_valid while in_ready = 0: the byte is held by upstream, not lost.

Optional Feature:
- Macro PNODE_SAT_EN.
- Defined: the accumulator saturates at -2^(ACC_W-1) and 2^(ACC_W-1)-1 on every MAC instead of wrapping. A saturated-low acc stays clamped until the next add moves it inward.
- Undefined: two's-complement wrap. No saturation logic is built.

Test Plan:
- N_IN=4, address=8'h05: WR_W w = {3,-1,4,0}, WR_X x = {2,5,4,9}, RUN, RD -> busy high exactly 4 cycles; out_data = 8'h11 (17).
- Weights {-2,0,0,0}, x {10,...}, RUN, RD -> acc = -20, out_data = 8'h00. Weights/x all 127 -> acc = 64516, out_data = 8'h7F.
- ACC_W=16, all 127, N_IN=4 -> without PNODE_SAT_EN acc = -1020, out_data = 8'h00. With PNODE_SAT_EN acc = 32767, out_data = 8'h7F.
- Frame to 8'h06 with WR_W idx 0 payload 8'h55, then frame to 8'h05 RD -> node 5 weight unchanged; payload 8'h55 not treated as ADDR; RD returns the prior result. WR_W idx = 7 (>= N_IN) -> no register change.
- RD with out_ready low for 5 cycles -> out_valid held, out_data stable, in_ready = 0; single transfer when out_ready goes high, then in_ready = 1.
- Assert nRst 2 cycles into RUN -> busy = 0, out_valid = 0, and all weights/x/result = 0 on the next cycle; a subsequent RD returns 8'h00.
